// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit Thumb-subset core.
// Owns the PC, fetches halfwords over req/ack and hands each instruction to the execute unit.
module fetch_sequencer #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
  parameter int                MEM_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              halt_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [15:0]       imem_rdata_i,
  output logic [15:0]       instr_o,
  input  logic [3:0]        opcode_i,
  output logic              exec_start_o,
  input  logic              exec_done_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              fault_o,
  output logic [15:0]       retired_o,
  output logic [2:0]        state_o
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       retired_q, retired_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              halt_pend_q, halt_pend_d;
  logic              exec_start_q, exec_start_d;
  logic              imem_req_q, busy_q, fault_q;
  logic              busy_d;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == 4'd10) || (op == 4'd12);
  endfunction

  // Next-state, PC/retire bookkeeping and fetch timeout.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retired_d    = retired_q;
    tcnt_d       = tcnt_q;
    exec_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !halt_i) begin
          state_d = S_FETCH;
          tcnt_d  = {TW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          tcnt_d  = {TW{1'b0}};
          state_d = S_DECODE;
        end else if (tcnt_q == TCNT_LAST) begin
          tcnt_d  = {TW{1'b0}};
          state_d = S_FAULT;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
        end
      end
      S_DECODE: begin
        exec_start_d = 1'b1;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done_i) begin
          retired_d = retired_q + 16'd1;
          if (branch_taken_i && is_branch(opcode_i)) begin
            pc_d = branch_target_i & ~ADDR_W'(1);
          end else begin
            pc_d = pc_q + ADDR_W'(2);
          end
          // A halt seen on the retiring cycle itself still stops the core.
          state_d = (halt_pend_q || halt_i) ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);

    if (state_d == S_IDLE) begin
      halt_pend_d = 1'b0;
    end else if (halt_i && (state_q == S_FETCH || state_q == S_DECODE || state_q == S_EXEC)) begin
      halt_pend_d = 1'b1;
    end else begin
      halt_pend_d = halt_pend_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 16'h0000;
      retired_q    <= 16'h0000;
      tcnt_q       <= {TW{1'b0}};
      halt_pend_q  <= 1'b0;
      exec_start_q <= 1'b0;
      imem_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retired_q    <= retired_d;
      tcnt_q       <= tcnt_d;
      halt_pend_q  <= halt_pend_d;
      exec_start_q <= exec_start_d;
      imem_req_q   <= (state_d == S_FETCH);
      busy_q       <= busy_d;
      fault_q      <= fault_q | (state_d == S_FAULT);
    end
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_q;
  assign instr_o      = instr_q;
  assign exec_start_o = exec_start_q;
  assign pc_o         = pc_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;
  assign retired_o    = retired_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized instruction
// streams checked against a transaction-level PC/retire model.
module tb_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, halt_i;
  logic        imem_req_o, imem_ack_i;
  logic [15:0] imem_addr_o, imem_rdata_i, instr_o;
  logic [3:0]  opcode_i;
  logic        exec_start_o, exec_done_i, branch_taken_i;
  logic [15:0] branch_target_i, pc_o, retired_o;
  logic        busy_o, fault_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_retired;
  logic        m_idle;

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .halt_i(halt_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .instr_o(instr_o), .opcode_i(opcode_i),
    .exec_start_o(exec_start_o), .exec_done_i(exec_done_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .pc_o(pc_o), .busy_o(busy_o), .fault_o(fault_o),
    .retired_o(retired_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One instruction from its first FETCH cycle to retirement, with stray inputs sprinkled
  // into the phases where they must be ignored.
  task automatic exec_one(input logic [15:0] rdata, input int ack_wait, input logic [3:0] op,
                          input logic br, input logic [15:0] tgt, input int done_wait,
                          input logic hlt, input string tag);
    chk({tag, ".req"}, imem_req_o, 1);
    chk({tag, ".addr"}, imem_addr_o, m_pc);
    for (int i = 0; i < ack_wait; i++) begin
      exec_done_i    = 1'($urandom_range(0, 1));
      branch_taken_i = 1'($urandom_range(0, 1));
      tick();
      chk({tag, ".fetch_wait"}, state_o, 1);
      chk({tag, ".addr_stable"}, imem_addr_o, m_pc);
      chk({tag, ".ret_fetch"}, retired_o, m_retired);
    end
    exec_done_i  = 1'b0;
    imem_ack_i   = 1'b1;
    imem_rdata_i = rdata;
    tick();
    imem_ack_i   = 1'b0;
    imem_rdata_i = 16'($urandom);
    chk({tag, ".decode"}, state_o, 2);
    chk({tag, ".instr"}, instr_o, rdata);
    chk({tag, ".xs_dec"}, exec_start_o, 0);
    chk({tag, ".req_dec"}, imem_req_o, 0);
    halt_i      = hlt;
    imem_ack_i  = 1'($urandom_range(0, 1));
    exec_done_i = 1'($urandom_range(0, 1));
    tick();
    halt_i = 1'b0;
    chk({tag, ".exec"}, state_o, 3);
    chk({tag, ".xs_pulse"}, exec_start_o, 1);
    exec_done_i = 1'b0;
    for (int i = 0; i < done_wait; i++) begin
      imem_ack_i = 1'($urandom_range(0, 1));
      tick();
      chk({tag, ".exec_wait"}, state_o, 3);
      chk({tag, ".xs_low"}, exec_start_o, 0);
      chk({tag, ".instr_hold"}, instr_o, rdata);
      chk({tag, ".pc_hold"}, pc_o, m_pc);
      chk({tag, ".ret_hold"}, retired_o, m_retired);
    end
    imem_ack_i      = 1'($urandom_range(0, 1));
    opcode_i        = op;
    branch_taken_i  = br;
    branch_target_i = tgt;
    exec_done_i     = 1'b1;
    tick();
    exec_done_i    = 1'b0;
    imem_ack_i     = 1'b0;
    branch_taken_i = 1'b0;
    m_retired = m_retired + 16'd1;
    if (br && (op == 4'd10 || op == 4'd12)) m_pc = {tgt[15:1], 1'b0};
    else m_pc = m_pc + 16'd2;
    m_idle = hlt;
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".retired"}, retired_o, m_retired);
    chk({tag, ".state_after"}, state_o, hlt ? 0 : 1);
    chk({tag, ".busy_after"}, busy_o, hlt ? 0 : 1);
    chk({tag, ".xs_after"}, exec_start_o, 0);
    if (!hlt) chk({tag, ".next_addr"}, imem_addr_o, m_pc);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; halt_i = 1'b0; imem_ack_i = 1'b0; imem_rdata_i = 16'h0000;
    opcode_i = 4'd0; exec_done_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 16'h0000;
    m_pc = 16'h0000; m_retired = 16'h0000; m_idle = 1'b1;
    repeat (2) tick();
    chk("rst.state", state_o, 0);
    chk("rst.pc", pc_o, 16'h0000);
    chk("rst.instr", instr_o, 16'h0000);
    chk("rst.req", imem_req_o, 0);
    chk("rst.xs", exec_start_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.fault", fault_o, 0);
    chk("rst.retired", retired_o, 16'h0000);
    reset_i = 1'b0;
    tick();
    chk("idle_hold", state_o, 0);

    // T1: async reset in the middle of a fetch
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("t1.fetch", state_o, 1);
    tick();
    reset_i = 1'b1;
    #1;
    chk("t1.async_state", state_o, 0);
    chk("t1.async_req", imem_req_o, 0);
    chk("t1.async_busy", busy_o, 0);
    tick(); reset_i = 1'b0; tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("t1.req", imem_req_o, 1);
    chk("t1.addr", imem_addr_o, 16'h0000);
    m_idle = 1'b0;

    // T2: ack on the third FETCH cycle
    exec_one(16'h2305, 2, 4'd2, 1'b0, 16'h0000, 1, 1'b0, "t2");
    chk("t2.pc_abs", pc_o, 16'h0002);

    // T3: taken branch with a branch opcode, then branch_taken with a non-branch opcode
    exec_one(16'hE004, 0, 4'd10, 1'b1, 16'h0031, 0, 1'b0, "t3a");
    chk("t3a.pc_abs", pc_o, 16'h0030);
    exec_one(16'h1234, 1, 4'd4, 1'b1, 16'h0777, 2, 1'b0, "t3b");
    chk("t3b.pc_abs", pc_o, 16'h0032);

    // T5: PC wrap with halt pulsed in DECODE and minimum-latency exec_done
    exec_one(16'hE7FF, 0, 4'd12, 1'b1, 16'hFFFF, 0, 1'b0, "t5a");
    chk("t5a.pc_abs", pc_o, 16'hFFFE);
    exec_one(16'h0000, 0, 4'd3, 1'b0, 16'h0000, 0, 1'b1, "t5b");
    chk("t5b.pc_abs", pc_o, 16'h0000);
    chk("t5b.idle", state_o, 0);

    start_i = 1'b1; halt_i = 1'b1; tick(); start_i = 1'b0; halt_i = 1'b0;
    chk("start_halt.idle", state_o, 0);

    // Randomized instruction stream, including the last-cycle ack boundary
    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [3:0] op;
      if (m_idle) begin
        start_i = 1'b1; tick(); start_i = 1'b0;
        chk("rnd.restart", state_o, 1);
        m_idle = 1'b0;
      end
      sel = int'($urandom_range(0, 3));
      op  = (sel == 0) ? 4'd10 : (sel == 1) ? 4'd12 : 4'($urandom_range(0, 15));
      exec_one(16'($urandom), (n % 10 == 0) ? 14 : int'($urandom_range(0, 6)), op,
               1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(0, 4)),
               ($urandom_range(0, 7) == 0), "rnd");
    end

    // T4: fetch timeout, sticky fault, start ignored until reset
    if (m_idle) begin
      start_i = 1'b1; tick(); start_i = 1'b0;
    end
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("t4.still_fetch", state_o, 1);
    end
    tick();
    chk("t4.state", state_o, 4);
    chk("t4.fault", fault_o, 1);
    chk("t4.req", imem_req_o, 0);
    chk("t4.busy", busy_o, 0);
    chk("t4.xs", exec_start_o, 0);
    start_i = 1'b1; repeat (3) tick(); start_i = 1'b0;
    chk("t4.start_ignored", state_o, 4);
    chk("t4.sticky", fault_o, 1);
    reset_i = 1'b1;
    #1;
    chk("t4.rst_fault", fault_o, 0);
    chk("t4.rst_state", state_o, 0);
    chk("t4.rst_retired", retired_o, 16'h0000);
    tick(); reset_i = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
